byte_parity_checker: RTL

//  Receive-side counterpart of the byte parity generator. Accepts 9-bit parity-protected

---
 rtl/byte_parity_pkg.sv | 29 ++
 rtl/byte_parity_calc.sv | 12 +
 rtl/byte_parity_checker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/byte_parity_pkg.sv
// Shared types, widths and the masked-parity helper for the byte parity checker.
package byte_parity_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = 9;

    typedef enum logic [1:0] {
        S_OK    = 2'd0,
        S_WARN  = 2'd1,
        S_ALARM = 2'd2
    } bpc_state_t;

    // Stage-1 payload: received word plus the mask it was generated with
    typedef struct packed {
        logic [DATA_W-1:0] en;
        logic [WORD_W-1:0] dp;
    } bpc_word_t;

    // Stage-2 payload: checked data and its mismatch flag
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              perr;
    } bpc_chk_t;

    function automatic logic parity8(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] en);
        return ^(d & en);
    endfunction

endpackage

// File: rtl/byte_parity_calc.sv
// Combinational parity recompute over enabled bits and compare with the received parity bit.
module byte_parity_calc
    import byte_parity_pkg::*;
(
    input  logic [WORD_W-1:0] dp,
    input  logic [DATA_W-1:0] en,
    output logic              perr_c
);

    assign perr_c = parity8(dp[DATA_W-1:0], en) ^ dp[WORD_W-1];

endmodule

// File: rtl/byte_parity_checker.sv
// Two-stage valid/ready parity checker with saturating error count and burst-error health FSM.
module byte_parity_checker
    import byte_parity_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned ERR_THRESH = 3,
    parameter int unsigned GOOD_RUN   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_dp,
    input  logic [DATA_W-1:0] in_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_d,
    output logic              out_perr,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              alarm,
    input  logic              clr
);

    localparam int unsigned ERR_W = $clog2(ERR_THRESH + 1);
    localparam int unsigned GOOD_W = $clog2(GOOD_RUN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              v1_q, v1_d, v2_q, v2_d;
    bpc_word_t         s1_q, s1_d;
    bpc_chk_t          s2_q, s2_d;
    logic              ld1, ld2, beat, perr1_c;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ERR_W-1:0]  err_run_q, err_run_d;
    logic [GOOD_W-1:0] good_run_q, good_run_d;
    bpc_state_t        state_q, state_d;
    logic              alarm_q, alarm_d;

    byte_parity_calc u_calc (
        .dp     (s1_q.dp),
        .en     (s1_q.en),
        .perr_c (perr1_c)
    );

    // Pipeline advance: a stage loads when it is empty or its contents move on
    always_comb begin
        ld2  = !v2_q || out_ready;
        ld1  = !v1_q || ld2;
        v1_d = v1_q;
        s1_d = s1_q;
        v2_d = v2_q;
        s2_d = s2_q;
        if (ld1) begin
            v1_d = in_valid;
            if (in_valid) s1_d = '{en: in_en, dp: in_dp};
        end
        if (ld2) begin
            v2_d = v1_q;
            if (v1_q) s2_d = '{data: s1_q.dp[DATA_W-1:0], perr: perr1_c};
        end
    end

    // Error count and health FSM advance only on output beats; clr overrides a beat
    always_comb begin
        beat       = v2_q && out_ready;
        cnt_d      = cnt_q;
        err_run_d  = err_run_q;
        good_run_d = good_run_q;
        state_d    = state_q;
        if (clr) begin
            cnt_d      = '0;
            err_run_d  = '0;
            good_run_d = '0;
            state_d    = S_OK;
        end else if (beat) begin
            if (s2_q.perr && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            unique case (state_q)
                S_OK: begin
                    if (s2_q.perr) begin
                        err_run_d  = ERR_W'(1);
                        good_run_d = '0;
                        state_d    = (ERR_THRESH <= 1) ? S_ALARM : S_WARN;
                    end
                end
                S_WARN: begin
                    if (s2_q.perr) begin
                        err_run_d  = err_run_q + ERR_W'(1);
                        good_run_d = '0;
                        if (32'(err_run_q) + 32'd1 >= ERR_THRESH) state_d = S_ALARM;
                    end else begin
                        err_run_d  = '0;
                        good_run_d = good_run_q + GOOD_W'(1);
                        if (32'(good_run_q) + 32'd1 >= GOOD_RUN) begin
                            state_d    = S_OK;
                            good_run_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
        alarm_d = (state_d == S_ALARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            s1_q       <= '0;
            v2_q       <= 1'b0;
            s2_q       <= '0;
            cnt_q      <= '0;
            err_run_q  <= '0;
            good_run_q <= '0;
            state_q    <= S_OK;
            alarm_q    <= 1'b0;
        end else begin
            v1_q       <= v1_d;
            s1_q       <= s1_d;
            v2_q       <= v2_d;
            s2_q       <= s2_d;
            cnt_q      <= cnt_d;
            err_run_q  <= err_run_d;
            good_run_q <= good_run_d;
            state_q    <= state_d;
            alarm_q    <= alarm_d;
        end
    end

    assign in_ready  = rst_n && ld1;
    assign out_valid = v2_q;
    assign out_d     = s2_q.data;
    assign out_perr  = s2_q.perr;
    assign err_cnt   = cnt_q;
    assign alarm     = alarm_q;

endmodule
